mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//  Load/store stage between execute and writeback. Takes the ALU address and store data, runs one
//  req/ack transaction on the data bus, and stalls the pipe until the bus acks.
//  Presents raw word read data and the byte offset to writeback, which does byte/half extraction.
// PARAMETERS
//  TIMEOUT_CYCLES  255  bus-ack watchdog limit, in cycles (used only with MEM_ACCESS_TIMEOUT_EN)
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   synchronous reset, active low
//  ex_valid        in   1   execute stage holds a valid instruction
//  ex_load         in   1   instruction is a load
//  ex_store        in   1   instruction is a store
//  ex_width        in   2   0=byte 1=half 2=word (3 treated as word)
//  ex_addr         in   32  effective address (alu_y)
//  ex_wdata        in   32  store data (rs2), right-justified
//  bus_req         out  1   transaction request
//  bus_we          out  1   1=write 0=read
//  bus_addr        out  32  word address {ex_addr[31:2],2'b00}
//  bus_wdata       out  32  store data replicated into the addressed lanes
//  bus_wstrb       out  4   byte lane enables (all 0 for reads)
//  bus_ack         in   1   transaction complete; bus_rdata valid the same cycle
//  bus_rdata       in   32  read word
//  stall           out  1   hold execute and upstream stages
//  done            out  1   1-cycle pulse: access retired, rdata valid
//  dmem_word_addr  out  2   ex_addr[1:0] of the retired access
//  dmem_rdata      out  32  captured bus_rdata of the last retired load
//  misaligned      out  1   1-cycle pulse: access rejected, no bus cycle
//  bus_err         out  1   1-cycle pulse: watchdog abort (0 without the option)
// BEHAVIOUR
//  Reset: FSM to IDLE. All outputs 0: bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, stall, done,
//   dmem_word_addr, dmem_rdata, misaligned, bus_err.
//  Access: ex_valid & (ex_load|ex_store). If ex_load and ex_store are both set, it is a store.
//  Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//   In IDLE, such an access pulses misaligned on the next cycle, issues no bus cycle and no stall.
//  FSM:
//   IDLE -> BUSY on an aligned access. The same edge registers bus_addr, bus_we, bus_wdata and bus_wstrb.
//    stall=1 combinationally in that IDLE cycle.
//   BUSY: bus_req=1, bus outputs held stable, stall=1.
//    On bus_ack: go to IDLE. bus_req drops the next cycle. stall=0 combinationally in the ack cycle.
//    done pulses the next cycle. dmem_rdata <= bus_rdata (loads only). dmem_word_addr <= addr[1:0].
//  Minimum latency: request -> done is 2 cycles with a zero-wait ack. A new access may start the cycle after ack.
//  Strobes:
//   byte: wstrb=1<<a[1:0], wdata={4{d[7:0]}}
//   half: wstrb=a[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}
//   word: wstrb=4'hf, wdata=d
//  done does not fire for misaligned accesses. Stores leave dmem_rdata unchanged.
//  bus_ack while IDLE is ignored.
//  Reset mid-BUSY: the transaction is abandoned. bus_req=0 after the edge; done and dmem_rdata are not updated.
// CONFIGURATION
//  MEM_ACCESS_TIMEOUT_EN defined:
//   An 8..32-bit counter clears on entry to BUSY and counts each BUSY cycle without ack.
//   On reaching TIMEOUT_CYCLES: FSM to IDLE, bus_err pulses, done stays 0, dmem_rdata unchanged.
//   An ack arriving in the same cycle wins over the timeout.
//  Undefined: no counter; BUSY waits indefinitely; bus_err is tied 0.
// TESTING
//  1. Load word, addr 0x100, ack after 3 wait cycles, rdata 0xDEADBEEF
//     -> bus_addr=0x100, wstrb=0, stall for 4 cycles, done, dmem_rdata=0xDEADBEEF, word_addr=0.
//  2. Store byte, addr 0x203, data 0x000000A5, zero-wait ack
//     -> bus_addr=0x200, wstrb=4'b1000, wdata=0xA5A5A5A5, done, dmem_rdata unchanged.
//  3. Store half, addr 0x202, data 0x1234 -> wstrb=4'b1100, wdata=0x12341234.
//     Then load half at 0x201 -> misaligned pulse, bus_req stays 0, no stall.
//  4. Back-to-back loads at 0x10 and 0x14 with zero-wait acks
//     -> second bus_req the cycle after the first ack; two done pulses with correct rdata.
//  5. rst_n low during BUSY -> bus_req=0 and stall=0 next cycle, no done; a following access works.
//  6. (EN, TIMEOUT_CYCLES=4) load with no ack -> bus_err pulse after 4 BUSY cycles, FSM IDLE, no done.

Source files
------------

// File: rtl/mem_access.sv
// Load/store stage: one req/ack data-bus transaction per access, stalling the pipe until ack.
// Optional bus-ack watchdog is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [1:0]  ex_width,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        done,
    output logic [1:0]  dmem_word_addr,
    output logic [31:0] dmem_rdata,
    output logic        misaligned,
    output logic        bus_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        access, misal, misal_hit, start, ack_take, tmo_hit, tmo_take;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;

    logic        bus_we_q;
    logic [31:0] bus_addr_q, bus_wdata_q;
    logic [3:0]  bus_wstrb_q;
    logic [1:0]  word_off_q, dmem_word_addr_q;
    logic [31:0] dmem_rdata_q;
    logic        done_q, misaligned_q;

    // Decode the access and build the lane-replicated store data and byte strobes.
    always_comb begin
        access  = ex_valid & (ex_load | ex_store);
        misal   = 1'b0;
        wstrb_d = 4'hf;
        wdata_d = ex_wdata;
        case (ex_width)
            2'd0: begin
                wstrb_d = 4'b0001 << ex_addr[1:0];
                wdata_d = {4{ex_wdata[7:0]}};
            end
            2'd1: begin
                misal   = ex_addr[0];
                wstrb_d = ex_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{ex_wdata[15:0]}};
            end
            default: misal = |ex_addr[1:0];
        endcase
        misal_hit = (state_q == ST_IDLE) & access & misal;
        start     = (state_q == ST_IDLE) & access & ~misal;
    end

    always_comb begin
        state_d  = state_q;
        ack_take = 1'b0;
        tmo_take = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus_ack) begin
                    state_d  = ST_IDLE;
                    ack_take = 1'b1;
                end else if (tmo_hit) begin
                    state_d  = ST_IDLE;
                    tmo_take = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            bus_we_q         <= 1'b0;
            bus_addr_q       <= '0;
            bus_wdata_q      <= '0;
            bus_wstrb_q      <= '0;
            word_off_q       <= '0;
            dmem_word_addr_q <= '0;
            dmem_rdata_q     <= '0;
            done_q           <= 1'b0;
            misaligned_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_q       <= ack_take;
            misaligned_q <= misal_hit;
            if (start) begin
                bus_addr_q  <= {ex_addr[31:2], 2'b00};
                bus_we_q    <= ex_store;
                bus_wdata_q <= wdata_d;
                bus_wstrb_q <= ex_store ? wstrb_d : 4'b0000;
                word_off_q  <= ex_addr[1:0];
            end
            if (ack_take) begin
                dmem_word_addr_q <= word_off_q;
                if (!bus_we_q) dmem_rdata_q <= bus_rdata;
            end
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);

    logic [CW-1:0] cnt_q;
    logic          bus_err_q;

    // Counter holds the number of ack-less BUSY cycles already completed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= tmo_take;
            if (start) begin
                cnt_q <= '0;
            end else if (state_q == ST_BUSY && !bus_ack) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign bus_err = bus_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) | tmo_take;
    assign tmo_hit = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign bus_req        = (state_q == ST_BUSY);
    assign stall          = start | ((state_q == ST_BUSY) & ~bus_ack);
    assign bus_we         = bus_we_q;
    assign bus_addr       = bus_addr_q;
    assign bus_wdata      = bus_wdata_q;
    assign bus_wstrb      = bus_wstrb_q;
    assign done           = done_q;
    assign dmem_word_addr = dmem_word_addr_q;
    assign dmem_rdata     = dmem_rdata_q;
    assign misaligned     = misaligned_q;

endmodule
